prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter: PC_W, default 12, program counter width in bits.
REQ-002 Parameter: START_ADDR, default 0, PC value loaded on each run start (PC_W bits).
REQ-003 Parameter: WAIT_STATES, default 1, extra stall cycles per memory instruction (0..15; 0 means no stall).
REQ-004 Parameter: CNT_W, default 16, cycle counter width.
REQ-005 The ports SHALL be:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  run request; level-held by the host for the whole run.
- halt_instr  in  1  current instruction is the program-end instruction.
- mem_op  in  1  current instruction is a load or store.
- branch_taken  in  1  branch condition true (control branch AND ALU branch flag).
- branch_abs  in  1  taken branch is absolute (1) or PC-relative (0).
- target  in  PC_W  absolute target; when relative, a two's-complement signed offset.
- prog_ctr  out  PC_W  instruction fetch address.
- instr_valid  out  1  execute enable; gates register-file and memory writes.
- busy  out  1  high in RUN or STALL.
- done  out  1  program completed; held until req falls.
- cycle_count  out  CNT_W  cycles spent in RUN plus STALL for the current or last run.

Function
REQ-006 There SHALL be four states:
- IDLE
- RUN
- STALL
- DONE
REQ-007 IDLE: prog_ctr holds; instr_valid=0, busy=0, done=0; req=1 -> RUN on the next edge, loading prog_ctr=START_ADDR and clearing cycle_count to 0.
REQ-008 RUN: instr_valid=1 combinationally; exactly one instruction executes per RUN cycle.
REQ-009 RUN next-PC priority, highest first:
- halt_instr -> DONE, prog_ctr held.
- mem_op with WAIT_STATES>0 -> STALL.
- branch_taken & branch_abs -> target.
- branch_taken & !branch_abs -> prog_ctr + sign-extended target.
- otherwise prog_ctr + 1.
REQ-010 All PC arithmetic SHALL be modulo 2**PC_W: PC 0xFFF+1 wraps to 0x000; a relative offset past either end wraps silently.
REQ-011 On RUN->STALL, the next PC (same branch rules as REQ-009) SHALL be latched and a wait counter loaded with WAIT_STATES.
REQ-012 STALL: instr_valid=0; prog_ctr holds; the counter decrements each cycle; at count 1 -> RUN with prog_ctr = latched next PC.
REQ-013 Memory-op latency SHALL be 1+WAIT_STATES cycles; other instructions take 1 cycle.
REQ-014 halt_instr together with mem_op or branch_taken: halt wins, no stall, no branch.
REQ-015 DONE: done=1, busy=0, instr_valid=0, prog_ctr and cycle_count frozen; req=0 -> IDLE (done falls the next cycle).
REQ-016 req=0 in RUN or STALL SHALL abort to IDLE next edge: no done pulse, the latched PC is discarded, cycle_count frozen.
REQ-017 cycle_count SHALL increment once per RUN or STALL cycle and saturate at 2**CNT_W-1.
REQ-018 req held high after DONE SHALL NOT restart the run; a new run requires req low for at least one cycle.

Reset
REQ-019 reset=0 SHALL asynchronously force:
- state IDLE
- prog_ctr=START_ADDR
- cycle_count=0
- wait counter 0
- instr_valid=0, busy=0, done=0
REQ-020 Reset asserted mid-run or mid-stall SHALL abandon the run with no done pulse.
REQ-021 After reset release, the sequencer SHALL stay IDLE until req is sampled high.

Structure
REQ-022 A shared package SHALL hold the state enum (IDLE/RUN/STALL/DONE) and the default PC_W and CNT_W constants used by the top level and the instruction ROM.
REQ-023 The wait-state down-counter SHALL be a sub-module, stall_counter, parametrised by its width.
REQ-024 The block SHALL replace the free-running PC and the ROM-driven done path in the core top level.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Straight-line run: req=1, halt at address 5 -> prog_ctr 0..5, instr_valid high 6 cycles, done=1, cycle_count=6.
- Branches: absolute target 0x040 taken at PC 3 -> next PC 0x040; relative target 0xFFE (-2) taken at PC 0x041 -> next PC 0x03F.
- Stall with WAIT_STATES=2: mem_op at PC 7 -> instr_valid 1,0,0; PC 7 held 3 cycles then 8; cycle_count increases by 3.
- Wrap and collision: PC 0xFFF with no branch -> 0x000; halt together with mem_op and branch_taken -> DONE next cycle, no stall.
- Abort and reset: req dropped in STALL -> IDLE, done never high; reset=0 asserted in RUN -> all outputs at reset values before the next clock edge.
- Handshake and saturation: req held high after DONE -> no restart; with CNT_W=4, a 20-cycle program -> cycle_count=15.

Source files
------------

// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer: state encoding and the
// default widths used by the core top level and the instruction ROM.
package prog_sequencer_pkg;

    localparam int PC_W_DEF  = 12;
    localparam int CNT_W_DEF = 16;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
    localparam logic [STATE_W-1:0] ST_STALL = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

    // Wide enough for the largest supported WAIT_STATES (15).
    localparam int WAIT_W = 4;

endpackage

// File: rtl/prog_sequencer_stall_counter.sv
// Loadable down-counter that times the wait states of a memory instruction.
module stall_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == W'(1));

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: drives the fetch address, gates execution, inserts
// memory wait states and counts the cycles of each run.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int                PC_W        = PC_W_DEF,
    parameter logic [PC_W-1:0]   START_ADDR  = '0,
    parameter int                WAIT_STATES = 1,
    parameter int                CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             halt_instr,
    input  logic             mem_op,
    input  logic             branch_taken,
    input  logic             branch_abs,
    input  logic [PC_W-1:0]  target,
    output logic [PC_W-1:0]  prog_ctr,
    output logic             instr_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    lat_pc_q, lat_pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PC_W-1:0]    next_pc;
    logic [CNT_W-1:0]   cnt_inc;
    logic               wc_load, wc_dec, wc_last;
    logic [WAIT_W-1:0]  wc_val, wc_count;

    // A same-width add is the sign-extended relative add modulo 2**PC_W.
    always_comb begin
        next_pc = pc_q + PC_W'(1);
        if (branch_taken) begin
            next_pc = branch_abs ? target : (pc_q + target);
        end
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : (cnt_q + CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        lat_pc_d = lat_pc_q;
        cnt_d    = cnt_q;
        wc_load  = 1'b0;
        wc_val   = '0;
        wc_dec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_RUN;
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_inc;
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (halt_instr) begin
                    state_d = ST_DONE;
                end else if (mem_op && (WAIT_STATES > 0)) begin
                    state_d  = ST_STALL;
                    lat_pc_d = next_pc;
                    wc_load  = 1'b1;
                    wc_val   = WAIT_W'(WAIT_STATES);
                end else begin
                    pc_d = next_pc;
                end
            end
            ST_STALL: begin
                cnt_d  = cnt_inc;
                wc_dec = 1'b1;
                if (!req) begin
                    state_d = ST_IDLE;
                    wc_load = 1'b1;
                end else if (wc_last) begin
                    state_d = ST_RUN;
                    pc_d    = lat_pc_q;
                end
            end
            ST_DONE: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= START_ADDR;
            lat_pc_q <= START_ADDR;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            lat_pc_q <= lat_pc_d;
            cnt_q    <= cnt_d;
        end
    end

    stall_counter #(.W(WAIT_W)) u_stall_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (wc_load),
        .load_val (wc_val),
        .dec      (wc_dec),
        .count    (wc_count),
        .last     (wc_last)
    );

    assign prog_ctr    = pc_q;
    assign instr_valid = (state_q == ST_RUN);
    assign busy        = (state_q == ST_RUN) || (state_q == ST_STALL);
    assign done        = (state_q == ST_DONE);
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: table of per-cycle vectors checked through a
// scoreboard, plus hand sequences for abort, reset and counter saturation.
module tb_prog_sequencer;

    typedef struct {
        logic        req;
        logic        halt;
        logic        mem;
        logic        bt;
        logic        ba;
        logic [11:0] tgt;
        logic [11:0] pc;
        logic        iv;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, halt_instr, mem_op, branch_taken, branch_abs;
    logic [11:0] target;
    logic [11:0] prog_ctr, prog_ctr_s;
    logic        instr_valid, busy, done;
    logic        instr_valid_s, busy_s, done_s;
    logic [15:0] cycle_count;
    logic [3:0]  cycle_count_s;

    int n_vec = 0;
    int n_err = 0;
    vec_t sb_q[$];
    vec_t vecs[30];

    always #5 clk = ~clk;

    prog_sequencer #(.PC_W(12), .START_ADDR(12'h000), .WAIT_STATES(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .req(req), .halt_instr(halt_instr), .mem_op(mem_op),
        .branch_taken(branch_taken), .branch_abs(branch_abs), .target(target),
        .prog_ctr(prog_ctr), .instr_valid(instr_valid), .busy(busy), .done(done),
        .cycle_count(cycle_count)
    );

    prog_sequencer #(.PC_W(12), .START_ADDR(12'h000), .WAIT_STATES(2), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .req(req), .halt_instr(halt_instr), .mem_op(mem_op),
        .branch_taken(branch_taken), .branch_abs(branch_abs), .target(target),
        .prog_ctr(prog_ctr_s), .instr_valid(instr_valid_s), .busy(busy_s), .done(done_s),
        .cycle_count(cycle_count_s)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic h, input logic m, input logic bt,
                                input logic ba, input logic [11:0] tgt, input logic [11:0] pc,
                                input logic iv, input logic b, input logic d, input logic [15:0] cnt);
        vec_t v;
        v.req = r; v.halt = h; v.mem = m; v.bt = bt; v.ba = ba; v.tgt = tgt;
        v.pc = pc; v.iv = iv; v.busy = b; v.done = d; v.cnt = cnt;
        return v;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        req          = v.req;
        halt_instr   = v.halt;
        mem_op       = v.mem;
        branch_taken = v.bt;
        branch_abs   = v.ba;
        target       = v.tgt;
        sb_q.push_back(v);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            vec_t e;
            e = sb_q.pop_front();
            check($sformatf("vec pc=%h", e.pc),
                  64'({prog_ctr, instr_valid, busy, done, cycle_count}),
                  64'({e.pc, e.iv, e.busy, e.done, e.cnt}));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        req = 0; halt_instr = 0; mem_op = 0; branch_taken = 0; branch_abs = 0; target = '0;

        // Straight line, hold after done, branches, stall, wrap, collision.
        vecs[0]  = mk(0,0,0,0,0,12'h000, 12'h000,0,0,0,16'd0);
        vecs[1]  = mk(1,0,0,0,0,12'h000, 12'h000,0,0,0,16'd0);
        vecs[2]  = mk(1,0,0,0,0,12'h000, 12'h000,1,1,0,16'd0);
        vecs[3]  = mk(1,0,0,0,0,12'h000, 12'h001,1,1,0,16'd1);
        vecs[4]  = mk(1,0,0,0,0,12'h000, 12'h002,1,1,0,16'd2);
        vecs[5]  = mk(1,0,0,0,0,12'h000, 12'h003,1,1,0,16'd3);
        vecs[6]  = mk(1,0,0,0,0,12'h000, 12'h004,1,1,0,16'd4);
        vecs[7]  = mk(1,1,0,0,0,12'h000, 12'h005,1,1,0,16'd5);
        vecs[8]  = mk(1,0,0,0,0,12'h000, 12'h005,0,0,1,16'd6);
        vecs[9]  = mk(1,0,0,0,0,12'h000, 12'h005,0,0,1,16'd6);
        vecs[10] = mk(0,0,0,0,0,12'h000, 12'h005,0,0,1,16'd6);
        vecs[11] = mk(0,0,0,0,0,12'h000, 12'h005,0,0,0,16'd6);
        vecs[12] = mk(1,0,0,0,0,12'h000, 12'h005,0,0,0,16'd6);
        vecs[13] = mk(1,0,0,0,0,12'h000, 12'h000,1,1,0,16'd0);
        vecs[14] = mk(1,0,0,0,0,12'h000, 12'h001,1,1,0,16'd1);
        vecs[15] = mk(1,0,0,0,0,12'h000, 12'h002,1,1,0,16'd2);
        vecs[16] = mk(1,0,0,1,1,12'h040, 12'h003,1,1,0,16'd3);
        vecs[17] = mk(1,0,0,0,0,12'h000, 12'h040,1,1,0,16'd4);
        vecs[18] = mk(1,0,0,1,0,12'hFFE, 12'h041,1,1,0,16'd5);
        vecs[19] = mk(1,0,0,1,1,12'h007, 12'h03F,1,1,0,16'd6);
        vecs[20] = mk(1,0,1,0,0,12'h000, 12'h007,1,1,0,16'd7);
        vecs[21] = mk(1,0,0,0,0,12'h000, 12'h007,0,1,0,16'd8);
        vecs[22] = mk(1,0,0,0,0,12'h000, 12'h007,0,1,0,16'd9);
        vecs[23] = mk(1,0,1,1,1,12'hFFF, 12'h008,1,1,0,16'd10);
        vecs[24] = mk(1,0,0,0,0,12'h000, 12'h008,0,1,0,16'd11);
        vecs[25] = mk(1,0,0,0,0,12'h000, 12'h008,0,1,0,16'd12);
        vecs[26] = mk(1,0,0,0,0,12'h000, 12'hFFF,1,1,0,16'd13);
        vecs[27] = mk(1,1,1,1,1,12'h123, 12'h000,1,1,0,16'd14);
        vecs[28] = mk(0,0,0,0,0,12'h000, 12'h000,0,0,1,16'd15);
        vecs[29] = mk(0,0,0,0,0,12'h000, 12'h000,0,0,0,16'd15);

        #12;
        check("reset outputs", 64'({prog_ctr, instr_valid, busy, done, cycle_count}), 64'd0);
        check("reset outputs small", 64'({prog_ctr_s, instr_valid_s, busy_s, done_s, cycle_count_s}), 64'd0);
        #6 reset = 1'b1;

        for (int i = 0; i < 30; i++) step(vecs[i]);

        // Abort from STALL: back to IDLE, no done, latched PC dropped.
        step(mk(1,0,0,0,0,12'h000, 12'h000,0,0,0,16'd15));
        step(mk(1,0,1,0,0,12'h000, 12'h000,1,1,0,16'd0));
        step(mk(0,0,0,0,0,12'h000, 12'h000,0,1,0,16'd1));
        step(mk(0,0,0,0,0,12'h000, 12'h000,0,0,0,16'd2));
        step(mk(0,0,0,0,0,12'h000, 12'h000,0,0,0,16'd2));

        // Asynchronous reset in the middle of a run.
        step(mk(1,0,0,0,0,12'h000, 12'h000,0,0,0,16'd2));
        step(mk(1,0,0,0,0,12'h000, 12'h000,1,1,0,16'd0));
        step(mk(1,0,0,0,0,12'h000, 12'h001,1,1,0,16'd1));
        @(negedge clk);
        #1;
        reset = 1'b0;
        req   = 1'b0;
        #1;
        check("async reset mid-run", 64'({prog_ctr, instr_valid, busy, done, cycle_count}), 64'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        step(mk(0,0,0,0,0,12'h000, 12'h000,0,0,0,16'd0));
        step(mk(0,0,0,0,0,12'h000, 12'h000,0,0,0,16'd0));

        // 20-cycle program: full counter reads 20, 4-bit counter saturates at 15.
        step(mk(1,0,0,0,0,12'h000, 12'h000,0,0,0,16'd0));
        for (int i = 0; i < 19; i++) step(mk(1,0,0,0,0,12'h000, 12'(i),1,1,0,16'(i)));
        step(mk(1,1,0,0,0,12'h000, 12'd19,1,1,0,16'd19));
        step(mk(1,0,0,0,0,12'h000, 12'd19,0,0,1,16'd20));
        @(negedge clk);
        #1;
        check("saturated count", 64'(cycle_count_s), 64'd15);
        check("small dut done", 64'({prog_ctr_s, done_s}), 64'({12'd19, 1'b1}));
        step(mk(1,0,0,0,0,12'h000, 12'd19,0,0,1,16'd20));
        step(mk(0,0,0,0,0,12'h000, 12'd19,0,0,1,16'd20));
        step(mk(0,0,0,0,0,12'h000, 12'd19,0,0,0,16'd20));

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) check("scoreboard drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
